uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_fifo.sv | 59 +++++
 rtl/uart_tx_cfg.sv | 133 +++++++++++++
 tb/tb_uart_tx_cfg.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and limits for the configurable UART transmitter
// Contents: tx_state_t (FSM encoding), DATA_WIDTH / FIFO_DEPTH legal limits,
//           is_pow2() helper for elaboration-time parameter checks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;
  localparam int FIFO_DEPTH_MIN = 2;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous frame FIFO with full/empty/count
// Ports: clk, rst_n (async, active-low), wr_en/wr_data (push, ignored when full),
//        rd_en/rd_data (pop, rd_data is the head entry, valid while !empty),
//        full, empty, count (entries stored, 0..DEPTH).
module uart_tx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Full is judged on the pre-edge count, so a simultaneous pop cannot make room.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - UART transmitter with per-frame parity/stop settings and frame FIFO
// Ports: CLK (one serial bit per rising edge), RST (async, active-low),
//        Parallel_data/data_valid/parity_EN/parity_type/stop_sel (frame write),
//        TX_OUT (registered line, idle high), busy (frame on line),
//        full, overflow (one-cycle pulse on rejected write), fifo_count.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [DATA_WIDTH-1:0]           Parallel_data,
  input  logic                            data_valid,
  input  logic                            parity_EN,
  input  logic                            parity_type,
  input  logic                            stop_sel,
  output logic                            TX_OUT,
  output logic                            busy,
  output logic                            full,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int         EW       = DATA_WIDTH + 3;
  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX ||
      FIFO_DEPTH < FIFO_DEPTH_MIN || !is_pow2(FIFO_DEPTH)) begin : g_param_check
    $error("uart_tx_cfg: illegal DATA_WIDTH or FIFO_DEPTH");
  end

  tx_state_t             state;
  tx_state_t             next_state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0]            bit_cnt;
  logic                  par_en_q;
  logic                  par_q;
  logic                  two_stop_q;
  logic                  tx_q;
  logic                  tx_next;
  logic                  pop;
  logic                  stop_last;
  logic                  fifo_empty;
  logic [EW-1:0]         head;

  // Entry layout: {data, parity_EN, parity_type, stop_sel}
  uart_tx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .wr_en   (data_valid),
    .wr_data ({Parallel_data, parity_EN, parity_type, stop_sel}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign TX_OUT = tx_q;
  assign busy   = (state != IDLE);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    tx_next    = 1'b1;
    stop_last  = !two_stop_q || (bit_cnt == 4'd1);
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          next_state = START;
          pop        = 1'b1;
        end
      end
      START:  next_state = DATA;
      DATA: begin
        if (bit_cnt == LAST_BIT) next_state = par_en_q ? PARITY : STOP;
      end
      PARITY: next_state = STOP;
      STOP: begin
        // Chain straight into the next start bit when more frames are queued.
        if (stop_last) begin
          if (!fifo_empty) begin
            next_state = START;
            pop        = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    // TX_OUT is registered, so the line level follows the state being entered.
    case (next_state)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg[0];
      PARITY:  tx_next = par_q;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      tx_q       <= 1'b1;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      two_stop_q <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state    <= next_state;
      tx_q     <= tx_next;
      overflow <= data_valid && full;
      // bit_cnt counts cycles spent in the current state.
      bit_cnt  <= (next_state == state) ? bit_cnt + 4'd1 : 4'd0;
      if (pop) begin
        shreg      <= head[EW-1:3];
        par_en_q   <= head[2];
        par_q      <= (^head[EW-1:3]) ^ head[1];
        two_stop_q <= head[0];
      end else if (next_state == DATA) begin
        shreg <= shreg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - scoreboard bench for uart_tx_cfg (DATA_WIDTH 8 and 5 instances)
module tb_uart_tx_cfg;

  typedef struct {
    logic [12:0] bits;
    int          len;
  } frame_t;

  logic       CLK;
  logic       RST;
  logic [7:0] d8;
  logic [4:0] d5;
  logic       dv8;
  logic       dv5;
  logic       p_en;
  logic       p_type;
  logic       s_sel;

  logic       tx8, busy8, full8, ovf8;
  logic [2:0] cnt8;
  logic       tx5, busy5, full5, ovf5;
  logic [2:0] cnt5;

  logic       mon_sel;
  logic       m_tx, m_busy, m_ovf;

  frame_t     sb[$];
  frame_t     cur;
  int         rem;
  logic [3:0] idx;
  int         run;
  int         last_run;
  int         frames_done;
  int         ovf_cycles;
  int         ovf_pulses;
  logic       ovf_prev;

  int         n_cmp;
  int         n_err;

  uart_tx_cfg dut8 (
    .CLK(CLK), .RST(RST), .Parallel_data(d8), .data_valid(dv8),
    .parity_EN(p_en), .parity_type(p_type), .stop_sel(s_sel),
    .TX_OUT(tx8), .busy(busy8), .full(full8), .overflow(ovf8), .fifo_count(cnt8)
  );

  uart_tx_cfg #(.DATA_WIDTH(5), .FIFO_DEPTH(4)) dut5 (
    .CLK(CLK), .RST(RST), .Parallel_data(d5), .data_valid(dv5),
    .parity_EN(p_en), .parity_type(p_type), .stop_sel(s_sel),
    .TX_OUT(tx5), .busy(busy5), .full(full5), .overflow(ovf5), .fifo_count(cnt5)
  );

  assign m_tx   = mon_sel ? tx5   : tx8;
  assign m_busy = mon_sel ? busy5 : busy8;
  assign m_ovf  = mon_sel ? ovf5  : ovf8;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as it should appear on the line: start, data LSB first, optional
  // parity making the total count of ones even/odd, one or two stop bits.
  function automatic frame_t build_frame(input int w, input logic [8:0] d,
                                         input logic pen, input logic pt, input logic ss);
    frame_t     f;
    logic [8:0] t;
    int         n;
    int         ones;
    f.bits = '0;
    t      = d;
    n      = 1;
    ones   = 0;
    for (int i = 0; i < w; i++) begin
      if (t[0]) begin
        f.bits = f.bits | (13'd1 << n);
        ones++;
      end
      t = t >> 1;
      n++;
    end
    if (pen) begin
      if ((pt && (ones % 2 == 0)) || (!pt && (ones % 2 == 1)))
        f.bits = f.bits | (13'd1 << n);
      n++;
    end
    f.bits = f.bits | (13'd1 << n);
    n++;
    if (ss) begin
      f.bits = f.bits | (13'd1 << n);
      n++;
    end
    f.len = n;
    return f;
  endfunction

  task automatic drive(input bit which, input bit valid, input logic [8:0] d,
                       input logic pen, input logic pt, input logic ss, input bit accept);
    @(posedge CLK);
    #1;
    dv8    = valid && !which;
    dv5    = valid && which;
    d8     = d[7:0];
    d5     = d[4:0];
    p_en   = pen;
    p_type = pt;
    s_sel  = ss;
    if (valid && accept) sb.push_back(build_frame(which ? 5 : 8, d, pen, pt, ss));
  endtask

  // No write, but scramble every other input to show frames in flight ignore them.
  task automatic idle_cycle();
    drive(1'b0, 1'b0, 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge CLK);
      #1;
      if (sb.size() == 0 && rem == 0 && !m_busy) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 32'(done), 1);
  endtask

  // Monitor: pops the expected frame when the line goes busy, then checks each bit.
  initial begin
    rem = 0; idx = '0; run = 0; last_run = 0; frames_done = 0;
    ovf_cycles = 0; ovf_pulses = 0; ovf_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        rem      = 0;
        idx      = '0;
        run      = 0;
        ovf_prev = 1'b0;
        sb.delete();
      end else begin
        if (m_busy) run++;
        else begin
          if (run != 0) last_run = run;
          run = 0;
        end
        if (m_ovf) ovf_cycles++;
        if (m_ovf && !ovf_prev) ovf_pulses++;
        ovf_prev = m_ovf;
        if (rem == 0 && m_busy && sb.size() != 0) begin
          cur = sb.pop_front();
          idx = '0;
          rem = cur.len;
        end
        if (rem != 0) begin
          chk("tx_bit", 32'(m_tx), 32'((cur.bits >> idx) & 13'd1));
          chk("busy_in_frame", 32'(m_busy), 1);
          idx = idx + 4'd1;
          rem--;
          if (rem == 0) frames_done++;
        end else begin
          chk("spurious_busy", 32'(m_busy), 0);
          chk("idle_line", 32'(m_tx), 1);
        end
      end
    end
  end

  initial begin
    int  f0;
    int  o0;
    int  p0;
    int  busy_seen;
    bit  ok;

    n_cmp = 0; n_err = 0;
    mon_sel = 1'b0;
    dv8 = 1'b0; dv5 = 1'b0; d8 = '0; d5 = '0;
    p_en = 1'b0; p_type = 1'b0; s_sel = 1'b0;
    RST = 1'b1;
    #2 RST = 1'b0;
    #1;
    chk("reset_tx", 32'(tx8), 1);
    chk("reset_busy", 32'(busy8), 0);
    chk("reset_full", 32'(full8), 0);
    chk("reset_overflow", 32'(ovf8), 0);
    chk("reset_count", 32'(cnt8), 0);
    repeat (3) @(negedge CLK);
    #1 RST = 1'b1;

    // Plain framing: 0xAA, no parity, one stop -> 10-cycle frame.
    drive(1'b0, 1'b1, 9'h0AA, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    wait_drain("drain_plain");
    chk("plain_busy_cycles", 32'(last_run), 10);

    // Parity: 0xEC even then odd -> 11-cycle frames.
    drive(1'b0, 1'b1, 9'h0EC, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    wait_drain("drain_even");
    chk("even_busy_cycles", 32'(last_run), 11);
    drive(1'b0, 1'b1, 9'h0EC, 1'b1, 1'b1, 1'b0, 1'b1);
    idle_cycle();
    wait_drain("drain_odd");
    chk("odd_busy_cycles", 32'(last_run), 11);

    // Back-to-back with two stop bits and scrambled inputs mid-frame.
    f0 = frames_done;
    drive(1'b0, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (5) idle_cycle();
    wait_drain("drain_b2b");
    chk("b2b_busy_cycles", 32'(last_run), 22);
    chk("b2b_frames", 32'(frames_done - f0), 2);

    // Overflow: six consecutive writes while idle; five accepted, sixth rejected.
    f0 = frames_done;
    o0 = ovf_pulses;
    p0 = ovf_cycles;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), i < 5);
      chk("full_pre_edge", 32'(full8), 32'(i == 5));
    end
    idle_cycle();
    chk("count_after_burst", 32'(cnt8), 4);
    wait_drain("drain_overflow");
    chk("overflow_frames", 32'(frames_done - f0), 5);
    chk("overflow_pulses", 32'(ovf_pulses - o0), 1);
    chk("overflow_cycles", 32'(ovf_cycles - p0), 1);

    // Randomized traffic on the 8-bit instance, never writing when the model says full.
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 2) == 0 && sb.size() < 4)
        drive(1'b0, 1'b1, 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      else
        idle_cycle();
    end
    idle_cycle();
    wait_drain("drain_random8");

    // Narrow instance: 5'b10011, odd parity, two stops -> 9-cycle frame.
    mon_sel = 1'b1;
    drive(1'b1, 1'b1, 9'h013, 1'b1, 1'b1, 1'b1, 1'b1);
    idle_cycle();
    wait_drain("drain_narrow");
    chk("narrow_busy_cycles", 32'(last_run), 9);
    for (int c = 0; c < 150; c++) begin
      if ($urandom_range(0, 2) == 0 && sb.size() < 4)
        drive(1'b1, 1'b1, 9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      else
        idle_cycle();
    end
    idle_cycle();
    wait_drain("drain_random5");
    mon_sel = 1'b0;

    // Reset during data bit 3 with two more frames queued.
    drive(1'b0, 1'b1, 9'h05A, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 9'h011, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLK);
      #1;
      if (rem != 0 && idx == 4'd5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_data_bit3", 32'(ok), 1);
    #2 RST = 1'b0;
    #1;
    chk("midframe_reset_tx", 32'(tx8), 1);
    chk("midframe_reset_busy", 32'(busy8), 0);
    chk("midframe_reset_count", 32'(cnt8), 0);
    chk("midframe_reset_full", 32'(full8), 0);
    @(negedge CLK);
    @(negedge CLK);
    #1 RST = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 30; c++) begin
      idle_cycle();
      if (busy8 || !tx8) busy_seen++;
    end
    chk("after_reset_quiet", 32'(busy_seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
